uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte FIFO between the CPU MMIO write path for UART TX (0x1000_0004) and uart_tx.
//  CPU stores a byte with no stall while space remains.
//  An internal drain FSM feeds bytes to uart_tx one at a time using its tx_start/busy handshake.
//  Replaces direct MMIO->uart_tx coupling so bursts of prints do not stall the core per byte.
// PARAMETERS
//  DEPTH_LOG2  4  FIFO depth = 2**DEPTH_LOG2 entries (16)
//  DATA_WIDTH  8  entry width, bits
// PORTS
//  clk       in   1           system clock (125 MHz)
//  resetn    in   1           asynchronous active-low reset
//  wr_valid  in   1           push request from MMIO decode
//  wr_data   in   DATA_WIDTH  byte to push
//  wr_ready  out  1           FIFO can accept; push = wr_valid & wr_ready
//  tx_start  out  1           one-cycle start pulse to uart_tx
//  tx_data   out  DATA_WIDTH  byte to uart_tx; stable from tx_start until the next pop
//  tx_busy   in   1           uart_tx busy flag
//  empty     out  1           no stored entries
//  full      out  1           2**DEPTH_LOG2 entries stored
// BEHAVIOUR
//  Reset (async assert, sync to clk on release):
//   - wr_ptr = 0, rd_ptr = 0, state = IDLE.
//   - tx_start = 0, tx_data = 0, empty = 1, full = 0, wr_ready = 1.
//   - Storage contents are not reset.
//  Pointers and status:
//   - wr_ptr/rd_ptr are DEPTH_LOG2+1 bits; the low bits index storage; the MSB resolves the wrap.
//   - count = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
//   - empty = (wr_ptr == rd_ptr).
//   - full  = (low bits equal) & (MSBs differ).
//   - wr_ready = ~full, combinational from registered pointers only, never from wr_valid.
//  Push: on an edge with wr_valid & wr_ready, mem[wr_ptr] <= wr_data and wr_ptr++.
//  Push while full: ignored, no pointer change. The MMIO side must hold mmio_ready low (stall).
//  Drain FSM:
//   - IDLE: if ~empty & ~tx_busy, tx_data <= mem[rd_ptr], rd_ptr++, tx_start <= 1, go to ARM.
//   - ARM: tx_start <= 0. If tx_busy == 1, go to SEND; otherwise stay in ARM
//     (uart_tx raises busy one cycle after tx_start).
//   - SEND: wait for tx_busy == 0, then go to IDLE.
//  Latency: a byte pushed at edge N into an empty FIFO with uart idle gives tx_start high after edge N+1.
//  Back-to-back bytes: the next tx_start comes 1 cycle after busy falls (IDLE re-evaluates).
//  Simultaneous push and pop: both pointers advance; count is unchanged.
//  Push and pop in the same cycle while full: push is refused (wr_ready = 0); the pop proceeds.
//  Push into an empty FIFO: IDLE uses the registered empty flag, so no same-cycle fall-through.
//  Reset mid-frame: the FSM returns to IDLE and the FIFO empties.
//   - uart_tx is reset by the same resetn, so no partial handshake survives.
//  tx_start is never high on two consecutive cycles; at most one byte is in flight.
// CONFIGURATION
//  UART_TX_FIFO_LEVEL_EN defined:
//   - Adds output port level [DEPTH_LOG2:0] = count, registered, reset 0.
//   - The MMIO read at 0x1000_0004 returns {level, busy} for software flow control.
//  UART_TX_FIFO_LEVEL_EN undefined:
//   - Port level is absent; no count register; software sees only full via wr_ready stall.
// TESTING
//  1. Reset released with wr_valid=0:
//     -> empty=1, full=0, wr_ready=1, tx_start=0 for 100 cycles.
//  2. Push 0x41 with uart idle:
//     -> tx_start=1 for exactly 1 cycle after the next edge, tx_data=0x41, empty=1 afterwards.
//  3. Push 16 bytes 0x00..0x0F back-to-back with tx_busy held 1:
//     -> full=1 after the 16th push.
//     -> A 17th push (0xAA) is refused, wr_ready=0; no byte is lost or overwritten.
//  4. Release tx_busy, modelling a 10-cycle frame per byte:
//     -> uart sees exactly 0x00..0x0F in order, one tx_start per busy cycle, then empty=1.
//  5. Continuous push every cycle while draining, across the pointer wrap (40 bytes):
//     -> output sequence equals input sequence; count never exceeds 16.
//  6. Assert resetn low in SEND with 5 entries stored:
//     -> tx_start=0, empty=1 immediately; after release, no stale byte is emitted.
//     -> With UART_TX_FIFO_LEVEL_EN defined, level=0 after the reset.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO between the CPU MMIO write path for UART TX and uart_tx.
//   The CPU pushes bytes without stalling while space remains; an internal
//   drain FSM hands bytes to uart_tx one at a time over tx_start/tx_busy.
//
// Ports
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   wr_valid  in   push request from MMIO decode
//   wr_data   in   byte to push
//   wr_ready  out  FIFO can accept (push = wr_valid & wr_ready)
//   tx_start  out  one-cycle start pulse to uart_tx
//   tx_data   out  byte to uart_tx, stable from tx_start until the next pop
//   tx_busy   in   uart_tx busy flag
//   empty     out  no stored entries
//   full      out  2**DEPTH_LOG2 entries stored
//   level     out  registered occupancy (only with UART_TX_FIFO_LEVEL_EN)
//
// Configuration
//   UART_TX_FIFO_LEVEL_EN  adds the registered occupancy output `level`.
//
// Drain FSM
//   state | meaning
//   IDLE  | waiting for a stored byte and an idle uart; pops on entry to ARM
//   ARM   | tx_start pulsed, waiting for uart_tx to raise busy
//   SEND  | frame in progress, waiting for busy to fall
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  output logic                  empty,
  output logic                  full
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  state_t                state;
  logic                  push_fire;
  logic                  pop_fire;

  // Status is derived from registered pointers only, so wr_ready never
  // depends on wr_valid and IDLE can never pop a byte pushed the same edge.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                    (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign wr_ready = ~full;

  assign push_fire = wr_valid & wr_ready;
  assign pop_fire  = (state == IDLE) & ~empty & ~tx_busy;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
    end else if (push_fire) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_start <= 1'b0;
          if (pop_fire) begin
            tx_data  <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            rd_ptr   <= rd_ptr + PTR_ONE;
            tx_start <= 1'b1;
            state    <= ARM;
          end
        end
        ARM: begin
          // uart_tx raises busy one cycle after the start pulse.
          tx_start <= 1'b0;
          if (tx_busy) begin
            state <= SEND;
          end
        end
        SEND: begin
          tx_start <= 1'b0;
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  // Tracks the post-edge pointer difference so level equals count with no lag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else begin
      level <= (wr_ptr + (push_fire ? PTR_ONE : PTR_ZERO))
             - (rd_ptr + (pop_fire  ? PTR_ONE : PTR_ZERO));
    end
  end
`else
  // Without the level option software only sees fullness via the wr_ready stall.
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       empty;
  logic       full;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: bytes accepted by the FIFO and not yet started on the uart.
  logic [7:0] model_q[$];

  // uart_tx model controls
  logic uart_hold = 1'b0;
  int   frame_min = 10;
  int   frame_max = 10;

  always #5 clk = ~clk;

  uart_tx_fifo dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .empty    (empty),
    .full     (full)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every start pulse must carry the oldest outstanding byte.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        checks++;
        if (prev_start) begin
          errors++;
          $display("FAIL start_consecutive: tx_start high two cycles at %0t", $time);
        end
        checks++;
        if (model_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start: got byte 0x%02h expected none at %0t", tx_data, $time);
        end else begin
          logic [7:0] exp_b;
          exp_b = model_q.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_data: got 0x%02h expected 0x%02h at %0t", tx_data, exp_b, $time);
          end
        end
      end
      prev_start = tx_start;
    end
  end

  // uart_tx model: busy rises one cycle after tx_start, lasts a random frame.
  initial begin
    int cnt;
    logic pend;
    cnt = 0;
    pend = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        cnt = 0;
        pend = 1'b0;
        tx_busy = 1'b0;
      end else begin
        if (tx_start) begin
          checks++;
          if (tx_busy || pend) begin
            errors++;
            $display("FAIL start_while_busy: tx_start=1 busy=%0d at %0t", tx_busy, $time);
          end
        end
        if (pend) begin
          cnt = $urandom_range(frame_max, frame_min);
          pend = 1'b0;
        end else if (cnt > 0) begin
          cnt--;
        end
        if (tx_start) pend = 1'b1;
        tx_busy = uart_hold || (cnt > 0);
      end
    end
  end

  // One stimulus cycle: check status against the model, then drive the inputs
  // for the coming edge. Returns whether the push will be accepted.
  task automatic push_cycle(input logic v, input logic [7:0] d, output logic acc);
    @(negedge clk);
    #1;
    check("empty", int'(empty), int'(model_q.size() == 0));
    check("full", int'(full), int'(model_q.size() == DEPTH));
    check("wr_ready", int'(wr_ready), int'(model_q.size() < DEPTH));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level", int'(level), model_q.size());
`endif
    wr_valid = v;
    wr_data  = d;
    acc = v && (model_q.size() < DEPTH);
    if (acc) model_q.push_back(d);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) push_cycle(1'b0, 8'h00, acc);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (model_q.size() != 0 && k < budget) begin
      idle(1);
      k++;
    end
    checks++;
    if (model_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", model_q.size());
    end
    idle(25);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [7:0] b;
    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_wr_ready", int'(wr_ready), 1);
    resetn = 1'b1;

    // 1: quiet after reset
    idle(100);

    // 2: single byte, exact latency
    push_cycle(1'b1, 8'h41, acc);
    push_cycle(1'b0, 8'h00, acc);
    check("lat_start_early", int'(tx_start), 0);
    push_cycle(1'b0, 8'h00, acc);
    check("lat_start", int'(tx_start), 1);
    check("lat_data", int'(tx_data), 8'h41);
    push_cycle(1'b0, 8'h00, acc);
    check("lat_start_pulse", int'(tx_start), 0);
    idle(20);
    check("single_empty", int'(empty), 1);

    // 3: fill with uart busy, then refused push
    uart_hold = 1'b1;
    idle(2);
    for (int i = 0; i < 16; i++) push_cycle(1'b1, 8'(i), acc);
    push_cycle(1'b1, 8'hAA, acc);
    check("refused_accept", int'(acc), 0);
    push_cycle(1'b0, 8'h00, acc);
    check("full_after_16", int'(full), 1);

    // 4: drain with 10-cycle frames
    uart_hold = 1'b0;
    drain(400);

    // 5: continuous push across the pointer wrap
    frame_min = 10;
    frame_max = 10;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      acc = 1'b0;
      while (!acc) push_cycle(1'b1, b, acc);
    end
    push_cycle(1'b0, 8'h00, acc);
    drain(600);

    // 5b: random gaps, random frame lengths
    frame_min = 1;
    frame_max = 12;
    for (int i = 0; i < 60; i++) begin
      logic v;
      v = ($urandom_range(3, 0) != 0);
      push_cycle(v, 8'($urandom), acc);
    end
    push_cycle(1'b0, 8'h00, acc);
    drain(900);

    // 6: reset while sending with 5 entries stored
    frame_min = 30;
    frame_max = 30;
    for (int i = 0; i < 6; i++) push_cycle(1'b1, 8'(8'hC0 + i), acc);
    push_cycle(1'b0, 8'h00, acc);
    push_cycle(1'b0, 8'h00, acc);
    check("pre_reset_empty", int'(empty), 0);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_tx_start", int'(tx_start), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_wr_ready", int'(wr_ready), 1);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("midrst_level", int'(level), 0);
`endif
    model_q.delete();
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
